sar_search: RTL and testbench

- Successive-approximation search controller that drives the trial operand of an external n-bit magnitude comparator and consumes its agtb/aeqb/altb flags.
- Determines an unknown unsigned target value presented on the comparator's other operand, MSB first, in at most N compare cycles.
- Sits on the driving side of the comparator interface: comparator input a is connected to trial, input b to the target, and the three flags return to this block.
- Used for threshold search and calibration loops.

---
 rtl/sar_search.sv | 121 ++++++++++++
 tb/tb_sar_search.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller driving an external magnitude comparator
// Optional macro SAR_STEP_CNT_EN adds the step_cnt output (compare cycles of the last search).
module sar_search #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_agtb,
    input  logic         cmp_aeqb,
    input  logic         cmp_altb,
    output logic [N-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
`ifdef SAR_STEP_CNT_EN
    ,
    output logic [$clog2(N+1)-1:0] step_cnt
`endif
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx, idx_m1;
    logic [N-1:0]    trial_nx, result_nx, decided;
    logic            err_nx;
    logic            flags_ok;

    assign flags_ok = ({cmp_agtb, cmp_aeqb, cmp_altb} == 3'b100) ||
                      ({cmp_agtb, cmp_aeqb, cmp_altb} == 3'b010) ||
                      ({cmp_agtb, cmp_aeqb, cmp_altb} == 3'b001);
    assign idx_m1   = idx - IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            err    <= 1'b0;
            idx    <= IW'(N - 1);
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            trial  <= trial_nx;
            result <= result_nx;
            err    <= err_nx;
            idx    <= idx_nx;
            busy   <= (state_nx == SEARCH);
            done   <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx  = state;
        trial_nx  = trial;
        idx_nx    = idx;
        result_nx = result;
        err_nx    = err;
        decided   = trial;
        // bit-idx decision: a trial above the target means that bit must be zero
        if (cmp_agtb) begin
            decided[idx] = 1'b0;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    trial_nx  = {1'b1, {(N-1){1'b0}}};
                    idx_nx    = IW'(N - 1);
                    result_nx = '0;
                    err_nx    = 1'b0;
                    state_nx  = SEARCH;
                end
            end
            SEARCH: begin
                if (!flags_ok) begin
                    err_nx    = 1'b1;
                    result_nx = trial;
                    state_nx  = DONE;
                end else if (cmp_aeqb) begin
                    result_nx = trial;
                    state_nx  = DONE;
                end else if (idx != '0) begin
                    trial_nx         = decided;
                    trial_nx[idx_m1] = 1'b1;
                    idx_nx           = idx_m1;
                end else begin
                    result_nx = decided;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef SAR_STEP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (state == IDLE && start) begin
            step_cnt <= '0;
        end else if (state == SEARCH) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - randomized self-checking bench for sar_search against a binary-search reference model
module tb_sar_search;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cmp_agtb, cmp_aeqb, cmp_altb;
    logic [N-1:0] trial, result;
    logic         busy, done, err;
`ifdef SAR_STEP_CNT_EN
    logic [$clog2(N+1)-1:0] step_cnt;
`endif

    int target    = 0;
    int inject    = 0;
    int cur_step  = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    sar_search #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp_agtb (cmp_agtb),
        .cmp_aeqb (cmp_aeqb),
        .cmp_altb (cmp_altb),
        .trial    (trial),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
`ifdef SAR_STEP_CNT_EN
        ,
        .step_cnt (step_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Comparator stub; a faulty step drives agtb and altb together.
    always_comb begin
        if (inject != 0 && cur_step == inject) begin
            {cmp_agtb, cmp_aeqb, cmp_altb} = 3'b101;
        end else begin
            cmp_agtb = (int'(trial) > target);
            cmp_aeqb = (int'(trial) == target);
            cmp_altb = (int'(trial) < target);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Trial at step s: bits above position N-s are already resolved to the target's, bit N-s is tried.
    function automatic int exp_trial(input int tgt, input int s);
        int sh;
        sh = N - s + 1;
        return ((tgt >> sh) << sh) | (1 << (N - s));
    endfunction

    // Search stops early once the trial equals the target, i.e. after the lowest set bit is tried.
    function automatic int exp_steps(input int tgt);
        int tz;
        if (tgt == 0) return N;
        tz = 0;
        while (((tgt >> tz) & 1) == 0) tz++;
        return N - tz;
    endfunction

    task automatic run(input int tgt, input int bad, input bit restart, input bit start_in_done);
        int m, res, er;
        target = tgt;
        inject = bad;
        m   = (bad != 0) ? bad : exp_steps(tgt);
        res = (bad != 0) ? exp_trial(tgt, bad) : tgt;
        er  = (bad != 0) ? 1 : 0;
        @(negedge clk);
        start = 1'b1;
        for (int s = 1; s <= m; s++) begin
            @(negedge clk);
            start = (restart && s == 2);
            cur_step = s;
            check("busy_search", int'(busy), 1);
            check("done_search", int'(done), 0);
            check("trial_seq", int'(trial), exp_trial(tgt, s));
            if (s == 1) begin
                check("err_clr", int'(err), 0);
                check("result_clr", int'(result), 0);
            end
        end
        @(negedge clk);
        start = start_in_done;
        cur_step = 0;
        check("done_pulse", int'(done), 1);
        check("busy_done", int'(busy), 0);
        check("result", int'(result), res);
        check("err", int'(err), er);
`ifdef SAR_STEP_CNT_EN
        check("step_cnt", int'(step_cnt), m);
`endif
        @(negedge clk);
        start = 1'b0;
        check("done_once", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("result_hold", int'(result), res);
        check("err_hold", int'(err), er);
        if (start_in_done) begin
            @(negedge clk);
            check("start_in_done_ign", int'(busy), 0);
        end
        inject = 0;
    endtask

    task automatic reset_mid_search();
        target = 7;
        inject = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_trial", int'(trial), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", int'(done), 0);
            check("rst_stays_idle", int'(busy), 0);
        end
    endtask

    initial begin
        int tgt, bad;
        #2;
        check("reset_trial", int'(trial), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        check("reset_err", int'(err), 0);
`ifdef SAR_STEP_CNT_EN
        check("reset_step_cnt", int'(step_cnt), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(7, 0, 1'b0, 1'b0);
        run(8, 0, 1'b0, 1'b0);
        run(0, 0, 1'b0, 1'b0);
        run(15, 0, 1'b0, 1'b0);
        run(5, 2, 1'b0, 1'b0);
        run(7, 0, 1'b1, 1'b1);
        reset_mid_search();
        run(7, 0, 1'b0, 1'b0);

        repeat (30) begin
            tgt = int'($urandom_range(0, (1 << N) - 1));
            bad = 0;
            if ($urandom_range(0, 3) == 0) bad = int'($urandom_range(1, exp_steps(tgt)));
            run(tgt, bad, ($urandom_range(0, 3) == 0) && exp_steps(tgt) >= 3,
                $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
